// File: rtl/id_pkg.sv
// Shared decode constants for the RV32I instruction-decode stage.
package id_pkg;

  typedef enum logic [3:0] {
    OPT_R       = 4'd0,
    OPT_I       = 4'd1,
    OPT_LOAD    = 4'd2,
    OPT_STORE   = 4'd3,
    OPT_LUI     = 4'd4,
    OPT_AUIPC   = 4'd5,
    OPT_BRANCH  = 4'd6,
    OPT_JAL     = 4'd7,
    OPT_JALR    = 4'd8,
    OPT_MULDIV  = 4'd9,
    OPT_FENCE   = 4'd10,
    OPT_SYSTEM  = 4'd11,
    OPT_ILLEGAL = 4'd15
  } optype_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_SUB_SRA = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

endpackage

// File: rtl/id_decoder.sv
// Purely combinational RV32I (+ optional M) instruction decoder.
module id_decoder
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RV_M = 0
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output optype_e         optype_o,
  output logic [4:0]      rd_addr_o,
  output logic [2:0]      funct3_o,
  output logic            alu_alt_o,
  output logic            rd_we_o,
  output logic            mem_re_o,
  output logic            mem_we_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            uses_rs1_o,
  output logic            uses_rs2_o,
  output logic            illegal_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm32;
  logic        has_rd;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];

  // Classify the opcode and build the 32-bit immediate; unknown encodings fall through as ILLEGAL with all controls low.
  always_comb begin
    imm32      = '0;
    optype_o   = OPT_ILLEGAL;
    funct3_o   = f3;
    alu_alt_o  = 1'b0;
    has_rd     = 1'b0;
    mem_re_o   = 1'b0;
    mem_we_o   = 1'b0;
    branch_o   = 1'b0;
    jump_o     = 1'b0;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE || f7 == F7_SUB_SRA) begin
          optype_o   = OPT_R;
          has_rd     = 1'b1;
          uses_rs1_o = 1'b1;
          uses_rs2_o = 1'b1;
          alu_alt_o  = (f7 == F7_SUB_SRA) && (f3 == 3'b000 || f3 == 3'b101);
        end else if (f7 == F7_MULDIV && RV_M != 0) begin
          optype_o   = OPT_MULDIV;
          has_rd     = 1'b1;
          uses_rs1_o = 1'b1;
          uses_rs2_o = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        optype_o   = OPT_I;
        has_rd     = 1'b1;
        uses_rs1_o = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          imm32     = {27'd0, inst_i[24:20]};
          alu_alt_o = (f3 == 3'b101) && inst_i[30];
        end else begin
          imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
        end
      end
      OPC_LOAD: begin
        optype_o   = OPT_LOAD;
        has_rd     = 1'b1;
        uses_rs1_o = 1'b1;
        mem_re_o   = 1'b1;
        imm32      = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OPC_STORE: begin
        optype_o   = OPT_STORE;
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
        mem_we_o   = 1'b1;
        imm32      = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      end
      OPC_LUI: begin
        optype_o = OPT_LUI;
        has_rd   = 1'b1;
        funct3_o = 3'b000;
        imm32    = {inst_i[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        optype_o = OPT_AUIPC;
        has_rd   = 1'b1;
        funct3_o = 3'b000;
        imm32    = {inst_i[31:12], 12'd0};
      end
      OPC_BRANCH: begin
        optype_o   = OPT_BRANCH;
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
        branch_o   = 1'b1;
        imm32      = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      end
      OPC_JAL: begin
        optype_o = OPT_JAL;
        has_rd   = 1'b1;
        jump_o   = 1'b1;
        funct3_o = 3'b000;
        imm32    = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      end
      OPC_JALR: begin
        optype_o   = OPT_JALR;
        has_rd     = 1'b1;
        uses_rs1_o = 1'b1;
        jump_o     = 1'b1;
        imm32      = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OPC_MISC_MEM: begin
        optype_o = OPT_FENCE;
        imm32    = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      OPC_SYSTEM: begin
        optype_o = OPT_SYSTEM;
        imm32    = {{20{inst_i[31]}}, inst_i[31:20]};
      end
      default: ;
    endcase
  end

  // Non-writing ops report rd=0 so the hazard and forwarding compares never see a stale field.
  assign rd_addr_o = has_rd ? inst_i[11:7] : 5'd0;
  assign rd_we_o   = has_rd && (inst_i[11:7] != 5'd0);
  assign illegal_o = (optype_o == OPT_ILLEGAL);
  assign imm_o     = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage with load-use hazard detection and the ID/EX pipeline register.
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RV_M = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     inst_i,
  input  logic            inst_valid_i,
  input  logic [XLEN-1:0] reg_data1_i,
  input  logic [XLEN-1:0] reg_data2_i,
  input  logic            flush_i,
  input  logic            stall_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] rs1_o,
  output logic [XLEN-1:0] rs2_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic [2:0]      funct3_o,
  output logic [3:0]      optype_o,
  output logic            alu_alt_o,
  output logic            mem_re_o,
  output logic            mem_we_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            illegal_o,
  output logic [4:0]      fwd_raddr1_o,
  output logic [4:0]      fwd_raddr2_o
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [2:0]      funct3;
    optype_e         optype;
    logic            alu_alt;
    logic            mem_re;
    logic            mem_we;
    logic            branch;
    logic            jump;
    logic            illegal;
    logic [4:0]      raddr1;
    logic [4:0]      raddr2;
  } idex_t;

  idex_t           idex_q, idex_d, dec;
  logic [XLEN-1:0] dec_imm;
  optype_e         dec_optype;
  logic [4:0]      dec_rd;
  logic [2:0]      dec_funct3;
  logic            dec_alt, dec_we, dec_re, dec_wr, dec_br, dec_jmp;
  logic            uses_rs1, uses_rs2, dec_ill;

  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  id_decoder #(
    .XLEN (XLEN),
    .RV_M (RV_M)
  ) u_dec (
    .inst_i     (inst_i),
    .imm_o      (dec_imm),
    .optype_o   (dec_optype),
    .rd_addr_o  (dec_rd),
    .funct3_o   (dec_funct3),
    .alu_alt_o  (dec_alt),
    .rd_we_o    (dec_we),
    .mem_re_o   (dec_re),
    .mem_we_o   (dec_wr),
    .branch_o   (dec_br),
    .jump_o     (dec_jmp),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2),
    .illegal_o  (dec_ill)
  );

  // A load in ID/EX whose destination feeds the instruction now in ID cannot be forwarded in time.
  assign stall_o = inst_valid_i & idex_q.valid & idex_q.mem_re & (idex_q.rd != 5'd0) &
                   ((uses_rs1 & (rs1_addr_o == idex_q.rd)) | (uses_rs2 & (rs2_addr_o == idex_q.rd)));

  // Assemble the decoded entry, then pick flush > hold > hazard bubble > load.
  always_comb begin
    dec = '0;
    if (inst_valid_i) begin
      dec.valid   = 1'b1;
      dec.pc      = pc_i;
      dec.imm     = dec_imm;
      dec.rs1     = reg_data1_i;
      dec.rs2     = reg_data2_i;
      dec.rd      = dec_rd;
      dec.rd_we   = dec_we;
      dec.funct3  = dec_funct3;
      dec.optype  = dec_optype;
      dec.alu_alt = dec_alt;
      dec.mem_re  = dec_re;
      dec.mem_we  = dec_wr;
      dec.branch  = dec_br;
      dec.jump    = dec_jmp;
      dec.illegal = dec_ill;
      dec.raddr1  = uses_rs1 ? rs1_addr_o : 5'd0;
      dec.raddr2  = uses_rs2 ? rs2_addr_o : 5'd0;
    end
    if (flush_i)      idex_d = '0;
    else if (stall_i) idex_d = idex_q;
    else if (stall_o) idex_d = '0;
    else              idex_d = dec;
  end

  // ID/EX pipeline register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign valid_o      = idex_q.valid;
  assign pc_o         = idex_q.pc;
  assign imm_o        = idex_q.imm;
  assign rs1_o        = idex_q.rs1;
  assign rs2_o        = idex_q.rs2;
  assign rd_addr_o    = idex_q.rd;
  assign rd_we_o      = idex_q.rd_we;
  assign funct3_o     = idex_q.funct3;
  assign optype_o     = idex_q.optype;
  assign alu_alt_o    = idex_q.alu_alt;
  assign mem_re_o     = idex_q.mem_re;
  assign mem_we_o     = idex_q.mem_we;
  assign branch_o     = idex_q.branch;
  assign jump_o       = idex_q.jump;
  assign illegal_o    = idex_q.illegal;
  assign fwd_raddr1_o = idex_q.raddr1;
  assign fwd_raddr2_o = idex_q.raddr2;

endmodule
